// File: rtl/cm42_digit_encoder.sv
// rtl/cm42_digit_encoder.sv - debounced 10-line active-low digit encoder with valid/ready output
//
// Purpose: inverse of the CM42 4-to-10 active-low decimal decoder. Ten active-low
// digit lines are registered, qualified for STABLE_CYCLES identical samples, and
// one BCD code per press is presented on a valid/ready handshake. All lines must
// return high for STABLE_CYCLES samples before the next press is accepted.
// A pattern with more than one line low is reported as ERR_CODE with code_err_o set.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   line_n_i[9:0] active-low digit lines, bit k low = digit k
//   code_ready_i  consumer accepts the code this cycle
//   code_valid_o  code_o / code_err_o are valid
//   code_o[3:0]   BCD digit 0..9, or ERR_CODE
//   code_err_o    presented pattern was multi-hot
//   err_count_o   saturating count of multi-hot events
//   busy_o        FSM is not idle
module cm42_digit_encoder #(
    parameter int         STABLE_CYCLES = 2,
    parameter logic [3:0] ERR_CODE      = 4'hF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] line_n_i,
    input  logic       code_ready_i,
    output logic       code_valid_o,
    output logic [3:0] code_o,
    output logic       code_err_o,
    output logic [7:0] err_count_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [9:0] IDLE_PAT = 10'h3FF;
    localparam logic [4:0] STABLE_W = 5'(STABLE_CYCLES);

    state_t     state_q, state_d;
    logic [9:0] line_q;
    logic [9:0] line_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       err_q, err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       busy_q, busy_d;

    logic       pat_idle;
    logic       pat_changed;
    logic [4:0] cnt_plus;
    logic [3:0] low_idx;
    logic [3:0] low_count;
    logic       multi_hot;
    logic       load;

    // Locate the low line and count how many lines are low.
    always_comb begin
        low_idx   = 4'd0;
        low_count = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (!line_q[k]) begin
                low_idx   = 4'(k);
                low_count = low_count + 4'd1;
            end
        end
    end

    assign multi_hot   = (low_count > 4'd1);
    assign pat_idle    = (line_q == IDLE_PAT);
    assign pat_changed = (line_q != line_prev_q);
    assign cnt_plus    = {1'b0, cnt_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!pat_idle) begin
                    // The first non-idle sample already counts as one stable sample.
                    if (STABLE_W == 5'd1) begin
                        state_d = PRESENT;
                        load    = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = 4'd1;
                    end
                end
            end
            QUALIFY: begin
                if (pat_changed) begin
                    if (pat_idle) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end else if (cnt_plus >= STABLE_W) begin
                    state_d = PRESENT;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_plus[3:0];
                end
            end
            PRESENT: begin
                if (code_ready_i) begin
                    state_d = RELEASE;
                    cnt_d   = 4'd0;
                end
            end
            RELEASE: begin
                // Counts consecutive idle samples; any press restarts the wait.
                if (pat_idle) begin
                    if (cnt_plus >= STABLE_W) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_plus[3:0];
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (load) begin
            err_d  = multi_hot;
            code_d = multi_hot ? ERR_CODE : low_idx;
            if (multi_hot && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            line_q      <= IDLE_PAT;
            line_prev_q <= IDLE_PAT;
            cnt_q       <= 4'd0;
            code_q      <= 4'd0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_n_i;
            line_prev_q <= line_q;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign code_valid_o = (state_q == PRESENT);
    assign code_o       = code_q;
    assign code_err_o   = err_q;
    assign err_count_o  = err_count_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cm42_digit_encoder.sv
// tb/tb_cm42_digit_encoder.sv - directed self-checking bench for cm42_digit_encoder
module tb_cm42_digit_encoder;

    logic       clk;
    logic       rst;
    logic [9:0] line_n;
    logic       code_ready;
    logic       code_valid;
    logic [3:0] code;
    logic       code_err;
    logic [7:0] err_count;
    logic       busy;

    int vectors;
    int miscompares;
    int pulses;

    cm42_digit_encoder #(
        .STABLE_CYCLES(2),
        .ERR_CODE     (4'hF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .line_n_i    (line_n),
        .code_ready_i(code_ready),
        .code_valid_o(code_valid),
        .code_o      (code),
        .code_err_o  (code_err),
        .err_count_o (err_count),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (code_valid) cnt++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 20) begin
            tick();
            i++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        line_n      = 10'h3FF;
        code_ready  = 1'b0;
        #12;
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_code", {28'd0, code}, 32'd0);
        check("rst_err", {31'd0, code_err}, 32'd0);
        check("rst_errcnt", {24'd0, err_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Digit 3 held 6 cycles, ready high: one-cycle valid 2 edges after first sample.
        line_n = 10'h3F7;
        code_ready = 1'b1;
        tick();
        check("d3_e0_valid", {31'd0, code_valid}, 32'd0);
        tick();
        check("d3_e1_valid", {31'd0, code_valid}, 32'd0);
        check("d3_e1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("d3_e2_valid", {31'd0, code_valid}, 32'd1);
        check("d3_code", {28'd0, code}, 32'd3);
        check("d3_err", {31'd0, code_err}, 32'd0);
        tick();
        check("d3_e3_valid", {31'd0, code_valid}, 32'd0);
        check("d3_code_hold", {28'd0, code}, 32'd3);
        count_valid(2, pulses);
        check("d3_no_repeat", pulses, 32'd0);
        line_n = 10'h3FF;
        wait_idle("d3_idle");

        // Digit 7 glitch for one cycle: never qualifies.
        line_n = 10'h37F;
        tick();
        line_n = 10'h3FF;
        count_valid(6, pulses);
        check("glitch_valid", pulses, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        // Digits 2 and 5 together: error code.
        line_n = 10'h3DB;
        tick();
        tick();
        tick();
        check("multi_valid", {31'd0, code_valid}, 32'd1);
        check("multi_code", {28'd0, code}, 32'hF);
        check("multi_err", {31'd0, code_err}, 32'd1);
        check("multi_errcnt", {24'd0, err_count}, 32'd1);
        tick();
        line_n = 10'h3FF;
        wait_idle("multi_idle");

        // Digit 9 with ready low; lines move while presenting.
        code_ready = 1'b0;
        line_n = 10'h1FF;
        tick();
        tick();
        tick();
        check("d9_valid", {31'd0, code_valid}, 32'd1);
        check("d9_code", {28'd0, code}, 32'd9);
        line_n = 10'h3FE;
        tick();
        tick();
        line_n = 10'h37F;
        tick();
        line_n = 10'h3FF;
        tick();
        tick();
        tick();
        check("d9_hold_valid", {31'd0, code_valid}, 32'd1);
        check("d9_hold_code", {28'd0, code}, 32'd9);
        check("d9_hold_err", {31'd0, code_err}, 32'd0);
        code_ready = 1'b1;
        tick();
        check("d9_after_xfer", {31'd0, code_valid}, 32'd0);
        count_valid(4, pulses);
        check("d9_single", pulses, 32'd0);
        wait_idle("d9_idle");

        // Digit 0 held 20 cycles: exactly one transfer; then digit 8.
        line_n = 10'h3FE;
        count_valid(20, pulses);
        check("d0_one_xfer", pulses, 32'd1);
        check("d0_code", {28'd0, code}, 32'd0);
        line_n = 10'h3FF;
        wait_idle("d0_idle");
        line_n = 10'h2FF;
        tick();
        tick();
        tick();
        check("d8_valid", {31'd0, code_valid}, 32'd1);
        check("d8_code", {28'd0, code}, 32'd8);
        tick();
        line_n = 10'h3FF;
        wait_idle("d8_idle");

        // Asynchronous reset while presenting.
        code_ready = 1'b0;
        line_n = 10'h3F7;
        tick();
        tick();
        tick();
        check("pre_rst_valid", {31'd0, code_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, code_valid}, 32'd0);
        check("arst_code", {28'd0, code}, 32'd0);
        check("arst_err", {31'd0, code_err}, 32'd0);
        check("arst_errcnt", {24'd0, err_count}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        line_n = 10'h3FF;
        tick();
        rst = 1'b0;
        count_valid(3, pulses);
        check("post_rst_quiet", pulses, 32'd0);

        // 256 multi-hot events: count saturates at 255.
        code_ready = 1'b1;
        for (int ev = 0; ev < 256; ev++) begin
            line_n = 10'h3DB;
            tick();
            tick();
            tick();
            line_n = 10'h3FF;
            tick();
            tick();
            tick();
            tick();
            if (ev == 0) check("sat_first", {24'd0, err_count}, 32'd1);
            if (ev == 253) check("sat_254", {24'd0, err_count}, 32'd254);
            if (ev == 254) check("sat_255", {24'd0, err_count}, 32'd255);
        end
        check("sat_256", {24'd0, err_count}, 32'd255);
        check("sat_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
